game_round_controller: RTL and testbench

Top-level sequencer for the binary-counting game. It generates a pseudo-random 8-bit target, schedules timed rounds, and checks the player's 8-bit switch guess against the target. It keeps the score and decides which value the seven-segment display controller shows, and when that value is blanked. It sits between the input pins (switches, buttons) and the display controller's `value` input.

---
 rtl/game_round_controller.sv | 198 +++++++++++++++++++
 tb/tb_game_round_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// Round sequencer for the binary-counting game: draws LFSR targets, times rounds,
// scores switch guesses and selects what the seven-segment display shows.
module game_round_controller #(
    parameter int TICK_DIV    = 1000,
    parameter int ROUND_TICKS = 10,
    parameter int SHOW_TICKS  = 3,
    parameter int MAX_ROUNDS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] guess,
    output logic [7:0] disp_value,
    output logic       disp_blank,
    output logic       round_active,
    output logic       correct,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int TCW = $clog2(TICK_DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEW    = 3'd1,
        ST_PLAY   = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t         state_r, state_s;
    logic [7:0]     lfsr_r;
    logic [7:0]     target_r, target_s;
    logic [7:0]     time_left_r, time_left_s;
    logic [7:0]     rounds_r, rounds_s;
    logic [7:0]     score_r, score_s;
    logic           hit_r, hit_s;
    logic [7:0]     show_r, show_s;
    logic [TCW-1:0] tcnt_r, tcnt_s;
    logic           tick_s;
    logic           correct_s;
    logic [7:0]     disp_value_r, disp_value_s;
    logic           disp_blank_r, disp_blank_s;
    logic           round_active_r, round_active_s;
    logic           correct_r;
    logic           game_over_r, game_over_s;

    // Next-state and datapath updates for the round sequencer
    always_comb begin
        state_s     = state_r;
        target_s    = target_r;
        time_left_s = time_left_r;
        rounds_s    = rounds_r;
        score_s     = score_r;
        hit_s       = hit_r;
        show_s      = show_r;
        correct_s   = 1'b0;
        tick_s      = ((state_r == ST_PLAY) || (state_r == ST_RESULT)) && (tcnt_r == TICK_LAST);
        if ((state_r == ST_PLAY) || (state_r == ST_RESULT)) begin
            tcnt_s = tick_s ? {TCW{1'b0}} : tcnt_r + TCW'(1);
        end else begin
            tcnt_s = tcnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_NEW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_NEW: begin
                target_s    = lfsr_r;
                time_left_s = 8'(ROUND_TICKS);
                rounds_s    = rounds_r + 8'd1;
                tcnt_s      = {TCW{1'b0}};
                state_s     = ST_PLAY;
            end
            ST_PLAY: begin
                // A submit takes priority over a tick that would expire the round
                if (submit) begin
                    if (guess == target_r) begin
                        score_s   = (score_r == 8'd255) ? 8'd255 : score_r + 8'd1;
                        hit_s     = 1'b1;
                        correct_s = 1'b1;
                    end else begin
                        hit_s = 1'b0;
                    end
                    tcnt_s  = {TCW{1'b0}};
                    show_s  = 8'd0;
                    state_s = ST_RESULT;
                end else if (tick_s) begin
                    time_left_s = time_left_r - 8'd1;
                    if (time_left_r == 8'd1) begin
                        hit_s   = 1'b0;
                        tcnt_s  = {TCW{1'b0}};
                        show_s  = 8'd0;
                        state_s = ST_RESULT;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_RESULT: begin
                if (tick_s) begin
                    if (show_r == 8'(SHOW_TICKS - 1)) begin
                        state_s = (rounds_r == 8'(MAX_ROUNDS)) ? ST_OVER : ST_NEW;
                    end else begin
                        show_s = show_r + 8'd1;
                    end
                end else begin
                    state_s = ST_RESULT;
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_s  = 8'd0;
                    rounds_s = 8'd0;
                    state_s  = ST_NEW;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so every output comes straight from a flop
    always_comb begin
        round_active_s = (state_s == ST_PLAY);
        game_over_s    = (state_s == ST_OVER);
        if (state_s == ST_PLAY) begin
            disp_value_s = target_s;
        end else begin
            disp_value_s = score_s;
        end
        // A miss blinks the score: dark on every odd-numbered show tick
        if ((state_s == ST_RESULT) && !hit_s) begin
            disp_blank_s = show_s[0];
        end else begin
            disp_blank_s = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            lfsr_r         <= 8'h01;
            target_r       <= 8'd0;
            time_left_r    <= 8'd0;
            rounds_r       <= 8'd0;
            score_r        <= 8'd0;
            hit_r          <= 1'b0;
            show_r         <= 8'd0;
            tcnt_r         <= {TCW{1'b0}};
            disp_value_r   <= 8'd0;
            disp_blank_r   <= 1'b0;
            round_active_r <= 1'b0;
            correct_r      <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            lfsr_r         <= lfsr_next(lfsr_r);
            target_r       <= target_s;
            time_left_r    <= time_left_s;
            rounds_r       <= rounds_s;
            score_r        <= score_s;
            hit_r          <= hit_s;
            show_r         <= show_s;
            tcnt_r         <= tcnt_s;
            disp_value_r   <= disp_value_s;
            disp_blank_r   <= disp_blank_s;
            round_active_r <= round_active_s;
            correct_r      <= correct_s;
            game_over_r    <= game_over_s;
        end
    end

    assign disp_value   = disp_value_r;
    assign disp_blank   = disp_blank_r;
    assign round_active = round_active_r;
    assign correct      = correct_r;
    assign game_over    = game_over_r;
    assign score        = score_r;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: stimulus plans whole rounds by their
// phase durations and queues per-cycle expected outputs; a monitor pops and compares.
module tb_game_round_controller;

    localparam int TD       = 4;
    localparam int RT       = 3;
    localparam int ST       = 2;
    localparam int MR       = 2;
    localparam int PLAY_LEN = RT * TD;
    localparam int RES_LEN  = ST * TD;

    typedef struct packed {
        logic [7:0] dv;
        logic       bl;
        logic       ra;
        logic       co;
        logic       go;
        logic [7:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start, submit;
    logic [7:0] guess;
    logic [7:0] disp_value, score;
    logic       disp_blank, round_active, correct, game_over;

    exp_t       exp_q[$];
    exp_t       mon_e, mon_a;
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc_n       = 0;
    logic [7:0] lf;
    int         score_m, rounds_m;
    logic [7:0] target_m;
    logic       hit_m;

    game_round_controller #(
        .TICK_DIV(TD), .ROUND_TICKS(RT), .SHOW_TICKS(ST), .MAX_ROUNDS(MR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .guess(guess),
        .disp_value(disp_value), .disp_blank(disp_blank), .round_active(round_active),
        .correct(correct), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic exp_t mk(input int dv, input logic bl, input logic ra,
                                input logic co, input logic go, input int sc);
        exp_t e;
        e.dv = 8'(dv); e.bl = bl; e.ra = ra; e.co = co; e.go = go; e.sc = 8'(sc);
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    // One clock edge: apply inputs, then queue the outputs expected after that edge
    task automatic cyc(input logic r, input logic s, input logic sb, input logic [7:0] g, input exp_t e);
        rst = r; start = s; submit = sb; guess = g;
        @(posedge clk);
        lf = r ? 8'h01 : lfsr_step(lf);
        exp_q.push_back(e);
        #1;
        rst = 1'b0; start = 1'b0; submit = 1'b0;
    endtask

    // Start pulse from IDLE or OVER; the target is the LFSR value during the NEW cycle
    task automatic begin_game();
        score_m  = 0;
        rounds_m = 1;
        cyc(1'b0, 1'b1, 1'b0, rbyte(), mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        target_m = lf;
    endtask

    // mode 0: correct at random cycle, 1: wrong guess, 2: timeout, 3: correct on expiring tick
    task automatic play_round(input int mode);
        int         d;
        logic [7:0] g;
        cyc(1'b0, rbit(), 1'b0, rbyte(), mk(target_m, 1'b0, 1'b1, 1'b0, 1'b0, score_m));
        d = (mode == 2) ? -1 : ((mode == 3) ? PLAY_LEN - 1 : int'($urandom_range(0, PLAY_LEN - 1)));
        for (int k = 0; k < PLAY_LEN; k++) begin
            if (k == d) begin
                if (mode == 1) begin
                    g     = target_m ^ 8'($urandom_range(1, 255));
                    hit_m = 1'b0;
                    cyc(1'b0, rbit(), 1'b1, g, mk(score_m, 1'b0, 1'b0, 1'b0, 1'b0, score_m));
                end else begin
                    score_m = (score_m < 255) ? score_m + 1 : 255;
                    hit_m   = 1'b1;
                    cyc(1'b0, rbit(), 1'b1, target_m, mk(score_m, 1'b0, 1'b0, 1'b1, 1'b0, score_m));
                end
                break;
            end else if (k == PLAY_LEN - 1) begin
                hit_m = 1'b0;
                cyc(1'b0, rbit(), 1'b0, rbyte(), mk(score_m, 1'b0, 1'b0, 1'b0, 1'b0, score_m));
            end else begin
                cyc(1'b0, rbit(), 1'b0, rbyte(), mk(target_m, 1'b0, 1'b1, 1'b0, 1'b0, score_m));
            end
        end
        for (int i = 1; i < RES_LEN; i++) begin
            cyc(1'b0, rbit(), rbit(), target_m,
                mk(score_m, !hit_m && (((i / TD) % 2) == 1), 1'b0, 1'b0, 1'b0, score_m));
        end
        if (rounds_m == MR) begin
            cyc(1'b0, rbit(), rbit(), target_m, mk(score_m, 1'b0, 1'b0, 1'b0, 1'b1, score_m));
        end else begin
            rounds_m++;
            cyc(1'b0, rbit(), rbit(), target_m, mk(score_m, 1'b0, 1'b0, 1'b0, 1'b0, score_m));
            target_m = lf;
        end
    endtask

    task automatic play_game(input int m0, input int m1);
        begin_game();
        play_round(m0);
        play_round(m1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, rbit(), target_m, mk(score_m, 1'b0, 1'b0, 1'b0, 1'b1, score_m));
        end
    endtask

    // Monitor: compare every presented output vector against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {disp_value, disp_blank, round_active, correct, game_over, score};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL outputs@cycle%0d: got dv=%02h bl=%b ra=%b co=%b go=%b sc=%02h, want dv=%02h bl=%b ra=%b co=%b go=%b sc=%02h",
                         cyc_n, mon_a.dv, mon_a.bl, mon_a.ra, mon_a.co, mon_a.go, mon_a.sc,
                         mon_e.dv, mon_e.bl, mon_e.ra, mon_e.co, mon_e.go, mon_e.sc);
            end
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; submit = 1'b0; guess = 8'd0;
        lf = 8'h01; score_m = 0; rounds_m = 0; target_m = 8'd0; hit_m = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 8'd0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        cyc(1'b1, 1'b1, 1'b1, 8'd0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, rbit(), rbyte(), mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        end

        play_game(0, 1);
        play_game(2, 3);
        for (int n = 0; n < 6; n++) begin
            play_game(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of the second round after a hit
        begin_game();
        play_round(0);
        cyc(1'b0, 1'b0, 1'b0, rbyte(), mk(target_m, 1'b0, 1'b1, 1'b0, 1'b0, score_m));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, rbyte(), mk(target_m, 1'b0, 1'b1, 1'b0, 1'b0, score_m));
        end
        cyc(1'b1, 1'b0, 1'b0, 8'd0, mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        score_m = 0; rounds_m = 0;
        cyc(1'b0, 1'b0, 1'b0, rbyte(), mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        begin_game();
        play_round(0);
        play_round(1);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
